// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle,
// signed/unsigned, and it holds the pipeline stall request while a division is in flight.
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                stallreq_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] dvd;      // dividend magnitude, shifted out as quotient bits shift in
   logic [DATA_W-1:0] dsr;
   logic [DATA_W-1:0] rem;
   logic              neg_q;
   logic              neg_r;

   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] rem_nxt;
   logic [DATA_W-1:0] quo_nxt;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;
   logic [DATA_W-1:0] mag1;
   logic [DATA_W-1:0] mag2;

   // NOTE: every signal assigned here gets a value on every path, so no latches are inferred.
   always_comb begin
      trial   = {rem, dvd[DATA_W-1]} - {1'b0, dsr};
      rem_nxt = trial[DATA_W] ? {rem[DATA_W-2:0], dvd[DATA_W-1]} : trial[DATA_W-1:0];
      quo_nxt = {dvd[DATA_W-2:0], ~trial[DATA_W]};
      quo_fix = neg_q ? -quo_nxt : quo_nxt;
      rem_fix = neg_r ? -rem_nxt : rem_nxt;
      // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
      mag1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
      mag2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
   end

   always_comb begin
      stallreq_o = 1'b0;
      if (rst) begin
         case (state)
            FREE:    stallreq_o = start_i && !annul_i;
            BYZERO:  stallreq_o = 1'b1;
            ON:      stallreq_o = !annul_i;
            default: stallreq_o = 1'b0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FREE;
         cnt      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  dvd   <= mag1;
                  dsr   <= mag2;
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  neg_r <= signed_div_i && opdata1_i[DATA_W-1];
                  state <= (opdata2_i == '0) ? BYZERO : ON;
               end
            end
            BYZERO: begin
               result_o <= '0;
               ready_o  <= 1'b1;
               state    <= END;
            end
            ON: begin
               if (annul_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
                  state    <= FREE;
               end else begin
                  rem <= rem_nxt;
                  dvd <= quo_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_CNT) begin
                     result_o <= {rem_fix, quo_fix};
                     ready_o  <= 1'b1;
                     state    <= END;
                  end
               end
            end
            END: begin
               if (!start_i || annul_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
                  state    <= FREE;
               end
            end
            default: state <= FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, stall window, signed corner cases,
// divide-by-zero, annul and asynchronous reset.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int n_check = 0;
   int n_pass  = 0;

   div_unit #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_check++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Holds start until ready, scrambling the operands after they are latched,
   // then drops start and checks the result is cleared on the next edge.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp_res, input int exp_stall);
      int stalls = 0;
      bit done   = 1'b0;
      @(negedge clk);
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sgn;
      annul_i      = 1'b0;
      start_i      = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         #1;
         if (ready_o) done = 1'b1;
         else begin
            if (stallreq_o) stalls++;
            @(negedge clk);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
         end
      end
      check({tag, "/ready"}, 64'(done), 64'd1);
      check({tag, "/stall_cycles"}, 64'(stalls), 64'(exp_stall));
      check({tag, "/result"}, result_o, exp_res);
      check({tag, "/stall_in_end"}, 64'(stallreq_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      #1;
      check({tag, "/ready_drop"}, 64'(ready_o), 64'd0);
      check({tag, "/result_drop"}, result_o, 64'd0);
   endtask

   initial begin
      bit seen_ready;
      rst          = 1'b0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset/result", result_o, 64'd0);
      check("reset/ready", 64'(ready_o), 64'd0);
      check("reset/stall", 64'(stallreq_o), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("idle/ready", 64'(ready_o), 64'd0);
      check("idle/stall", 64'(stallreq_o), 64'd0);

      run_div("u100_7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 33);
      run_div("s-7_2",    32'hFFFF_FFF9,  32'h0000_0002,  1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_div("s7_-2",    32'h0000_0007,  32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
      run_div("s-100_-7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 33);
      run_div("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000}, 33);
      run_div("u_big",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'h0000_0000}, 33);
      run_div("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 33);
      run_div("div0",     32'd5,          32'd0,          1'b0, 64'd0, 2);

      // start and annul together in FREE: nothing starts
      @(negedge clk);
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      start_i   = 1'b1;
      annul_i   = 1'b1;
      #1;
      check("start_annul/stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      #1;
      check("start_annul/ready", 64'(ready_o), 64'd0);
      check("start_annul/stall2", 64'(stallreq_o), 64'd0);
      start_i = 1'b0;
      annul_i = 1'b0;

      // annul during iteration 10 of 1000/3
      @(negedge clk);
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      signed_div_i = 1'b0;
      start_i      = 1'b1;
      repeat (11) @(negedge clk);
      #1;
      check("annul/stall_pre", 64'(stallreq_o), 64'd1);
      annul_i = 1'b1;
      #1;
      check("annul/stall_drop", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;
      #1;
      check("annul/ready", 64'(ready_o), 64'd0);
      check("annul/stall_free", 64'(stallreq_o), 64'd0);
      seen_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (ready_o) seen_ready = 1'b1;
      end
      check("annul/never_ready", 64'(seen_ready), 64'd0);
      run_div("u9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

      // asynchronous reset in the middle of ON, between edges
      @(negedge clk);
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_on/result", result_o, 64'd0);
      check("arst_on/ready", 64'(ready_o), 64'd0);
      check("arst_on/stall", 64'(stallreq_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_div("u100_7_rst", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

      // asynchronous reset while a result is being held
      @(negedge clk);
      opdata1_i = 32'd77;
      opdata2_i = 32'd10;
      start_i   = 1'b1;
      repeat (33) @(negedge clk);
      #1;
      check("arst_end/ready_pre", 64'(ready_o), 64'd1);
      check("arst_end/result_pre", result_o, {32'd7, 32'd7});
      rst = 1'b0;
      #1;
      check("arst_end/result", result_o, 64'd0);
      check("arst_end/ready", 64'(ready_o), 64'd0);
      check("arst_end/stall", 64'(stallreq_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned divider in the EX stage.
- It is the stall requester on the ctrl stall protocol: it holds its stall request high while a division is in flight, which freezes pc, if_id and id_ex until the result is available.
- It produces quotient and remainder for the hi/lo write-back path.
- A restoring algorithm computes one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width. Result width is 2*DATA_W. The iteration count equals DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  request a division. Held high by EX until ready_o is seen.
- annul_i  input  1  abort the current or requested division (flush).
- signed_div_i  input  1  1 = signed operation, 0 = unsigned.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- result_o  output  2*DATA_W  {remainder, quotient}.
- ready_o  output  1  result_o valid.
- stallreq_o  output  1  stall request to ctrl; 1 = Stop.

Behaviour:
- Reset (rst low, asynchronous), effective immediately:
  - state = FREE, cnt = 0.
  - result_o = 0, ready_o = 0, stallreq_o = 0.
  - Internal operand registers are cleared.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0, opdata1_i, opdata2_i and signed_div_i are latched on that edge.
  - If the divisor is 0, next state is BYZERO.
  - Otherwise the operands are converted to magnitudes when signed_div_i=1, cnt=0, and next state is ON.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next state is END with result_o = 0 (quotient 0, remainder 0).
- ON:
  - If annul_i=1, next state is FREE, with result 0 and ready 0.
  - Otherwise perform one restoring iteration per cycle:
    - Shift the partial remainder left by 1 and bring in the next dividend bit.
    - Trial-subtract the divisor.
    - If the result is non-negative, keep it and set the quotient bit to 1; else set the quotient bit to 0.
  - cnt increments each iteration.
  - On the edge completing the iteration with cnt = DATA_W-1, apply sign correction and register result_o, ready_o=1, next state END.
- Sign correction (signed_div_i=1 only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wrap) and remainder 0.
  - The magnitude of 0x80000000 is handled as unsigned 0x80000000.
- END:
  - ready_o=1 and result_o is held.
  - If start_i=0 or annul_i=1, next state is FREE, with ready_o=0 and result_o=0 on that edge.
  - Otherwise remain in END.
- stallreq_o is combinational:
  - 1 when state=FREE with start_i=1 and annul_i=0.
  - 1 in state BYZERO.
  - 1 in state ON with annul_i=0.
  - 0 in END and in all other cases.
- Latency:
  - Start sampled at edge E0, so ON is entered at E0 and the iterations run at edges E1..E32.
  - ready_o rises after E32; stallreq_o is high from the cycle before E0 through the cycle before E32.
  - Divide-by-zero: ready_o rises after E1.
- Operand inputs are ignored after latching; changes during ON have no effect.
- The divider stalls itself only via stallreq_o. ctrl's stall vector is not an input, because EX holds start_i steady while stalled.
- Simultaneous start_i and annul_i in FREE: annul wins, no operation starts, and stallreq_o=0.

Test Plan:
- Unsigned 100/7: start_i=1, signed_div_i=0, held → stallreq_o=1 for 33 cycles, then ready_o=1 and result_o={32'd2, 32'd14}. Drop start_i → ready_o=0 and result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero, 5/0 → ready_o=1 two cycles after start and result_o=0. stallreq_o=1 for exactly 2 cycles (FREE request cycle plus BYZERO).
- Annul: pulse annul_i at iteration 10 of 1000/3 → stallreq_o drops the same cycle, state returns to FREE, and ready_o never asserts. A fresh 9/3 start then yields quotient 3, remainder 0 after the normal latency.
- Async reset: assert rst low mid-ON, between clock edges → result_o, ready_o and stallreq_o all go to 0 immediately. After release, 100/7 completes correctly.
